// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding and memory layout constants.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    PT0,
    RDI,
    RDJ,
    WRI,
    WRJ,
    RDP,
    WRP
  } prga_state_t;

  localparam int MEM_DEPTH = 256;
  localparam logic [7:0] LEN_ADDR = 8'h00;

endpackage

// File: rtl/prga_decrypt.sv
// RC4 keystream generation and decryption of a length-prefixed ciphertext.
// Reads the scheduled S array, writes plaintext to PT with pt[0] = length.
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_rddata,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [DATA_W-1:0] ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [DATA_W-1:0] pt_wrdata,
  output logic              pt_wren
);

  prga_state_t       state, state_next;
  logic [ADDR_W-1:0] i, i_next, j, j_next, k, k_next;
  logic [DATA_W-1:0] len, len_next, si, si_next, sj, sj_next;
  logic [DATA_W-1:0] ct_byte, ct_byte_next;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      len     <= '0;
      si      <= '0;
      sj      <= '0;
      ct_byte <= '0;
    end else begin
      state   <= state_next;
      i       <= i_next;
      j       <= j_next;
      k       <= k_next;
      len     <= len_next;
      si      <= si_next;
      sj      <= sj_next;
      ct_byte <= ct_byte_next;
    end
  end

  // Next-state, datapath updates and memory port decode
  always_comb begin
    state_next   = state;
    i_next       = i;
    j_next       = j;
    k_next       = k;
    len_next     = len;
    si_next      = si;
    sj_next      = sj;
    ct_byte_next = ct_byte;
    rdy          = 1'b0;
    s_addr       = '0;
    s_wrdata     = '0;
    s_wren       = 1'b0;
    ct_addr      = '0;
    pt_addr      = '0;
    pt_wrdata    = '0;
    pt_wren      = 1'b0;

    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          i_next     = '0;
          j_next     = '0;
          state_next = LEN;
        end else begin
          state_next = IDLE;
        end
      end
      LEN: begin
        ct_addr    = ADDR_W'(LEN_ADDR);
        state_next = PT0;
      end
      PT0: begin
        len_next  = ct_rddata;
        pt_addr   = ADDR_W'(LEN_ADDR);
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == '0) begin
          state_next = IDLE;
        end else begin
          i_next     = ADDR_W'(1);
          k_next     = ADDR_W'(1);
          state_next = RDI;
        end
      end
      RDI: begin
        s_addr     = i;
        state_next = RDJ;
      end
      RDJ: begin
        si_next    = s_rddata;
        j_next     = j + ADDR_W'(s_rddata);
        s_addr     = j + ADDR_W'(s_rddata);
        state_next = WRI;
      end
      // The swap: s[i] takes s[j] first, then s[j] takes the saved s[i]
      WRI: begin
        sj_next    = s_rddata;
        s_addr     = i;
        s_wrdata   = s_rddata;
        s_wren     = 1'b1;
        ct_addr    = k;
        state_next = WRJ;
      end
      WRJ: begin
        s_addr       = j;
        s_wrdata     = si;
        s_wren       = 1'b1;
        ct_byte_next = ct_rddata;
        state_next   = RDP;
      end
      RDP: begin
        s_addr     = ADDR_W'(si + sj);
        state_next = WRP;
      end
      WRP: begin
        pt_addr   = k;
        pt_wrdata = s_rddata ^ ct_byte;
        pt_wren   = 1'b1;
        if (k == ADDR_W'(len)) begin
          state_next = IDLE;
        end else begin
          k_next     = k + ADDR_W'(1);
          i_next     = i + ADDR_W'(1);
          state_next = RDI;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
